// File: rtl/acorn_pkg.sv
// Shared types and constants for the ACORN seeding stage.
package acorn_pkg;

  localparam int SEED_W = 12;
  localparam logic [SEED_W-1:0] SEED_DEFAULT = 12'hACE;

  localparam logic [1:0] SEL_GPIO  = 2'b00;
  localparam logic [1:0] SEL_LA    = 2'b01;
  localparam logic [1:0] SEL_FB    = 2'b10;
  localparam logic [1:0] SEL_CONST = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RST_PH = 2'd1,
    LOAD   = 2'd2,
    WARMUP = 2'd3
  } state_e;

  // An all-zero seed would lock the PRNG, so substitute the default.
  function automatic logic [SEED_W-1:0] zero_guard(input logic [SEED_W-1:0] seed);
    return (seed == {SEED_W{1'b0}}) ? SEED_DEFAULT : seed;
  endfunction

endpackage

// File: rtl/acorn_seed_ctrl_if.sv
// Seed sources, load request and PRNG control outputs of the seeding stage.
interface acorn_seed_ctrl_if;
  import acorn_pkg::*;

  logic              load_i;
  logic [1:0]        select_i;
  logic [SEED_W-1:0] gpio_seed_i;
  logic [SEED_W-1:0] la_seed_i;
  logic [SEED_W-1:0] prng_out_i;
  logic [SEED_W-1:0] seed_o;
  logic              seed_load_o;
  logic              prng_rst_o;
  logic              ready_o;
  logic              overrun_o;

  modport master (
    output load_i, select_i, gpio_seed_i, la_seed_i, prng_out_i,
    input  seed_o, seed_load_o, prng_rst_o, ready_o, overrun_o
  );

  modport slave (
    input  load_i, select_i, gpio_seed_i, la_seed_i, prng_out_i,
    output seed_o, seed_load_o, prng_rst_o, ready_o, overrun_o
  );

endinterface

// File: rtl/acorn_sync_edge.sv
// Two-flop synchroniser for an asynchronous level plus a rising-edge detector
// built on a third flop; the pulse is one cycle wide.
module acorn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_s
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Synchroniser chain and edge-history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= async_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise_s = s2_r & ~s3_r;

endmodule

// File: rtl/acorn_seed_ctrl.sv
// Seeding controller for the ACORN PRNG: picks a seed source, and sequences
// PRNG reset, a one-cycle seed load and warm-up for every reseed request.
module acorn_seed_ctrl
  import acorn_pkg::*;
#(
  parameter int RST_CYCLES    = 4,
  parameter int WARMUP_CYCLES = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  acorn_seed_ctrl_if.slave  bus
);

  localparam int MAX_CYC = (RST_CYCLES > WARMUP_CYCLES) ? RST_CYCLES : WARMUP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP_CYCLES > 0) ? (WARMUP_CYCLES - 1) : 0);

  state_e            state_r;
  state_e            state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  logic [SEED_W-1:0] seed_r;
  logic [SEED_W-1:0] seed_s;
  logic [SEED_W-1:0] mux_seed_s;
  logic              ovr_r;
  logic              ovr_s;
  logic              prng_rst_r;
  logic              seed_load_r;
  logic              ready_r;
  logic              load_rise_s;

  acorn_sync_edge u_sync (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .async_in (bus.load_i),
    .rise_s   (load_rise_s)
  );

  // Seed source selection.
  always_comb begin
    mux_seed_s = SEED_DEFAULT;
    case (bus.select_i)
      SEL_GPIO:  mux_seed_s = bus.gpio_seed_i;
      SEL_LA:    mux_seed_s = bus.la_seed_i;
      SEL_FB:    mux_seed_s = bus.prng_out_i;
      SEL_CONST: mux_seed_s = SEED_DEFAULT;
      default:   mux_seed_s = SEED_DEFAULT;
    endcase
  end

  // Next-state, seed latch, overrun and counter logic.
  always_comb begin
    state_s = state_r;
    seed_s  = seed_r;
    ovr_s   = ovr_r;
    cnt_s   = {CNT_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (load_rise_s) begin
          state_s = RST_PH;
          seed_s  = zero_guard(mux_seed_s);
        end else begin
          state_s = IDLE;
        end
      end
      RST_PH: begin
        if (cnt_r == RST_LAST) state_s = LOAD;
        else                   state_s = RST_PH;
      end
      LOAD: begin
        if (WARMUP_CYCLES == 0) state_s = IDLE;
        else                    state_s = WARMUP;
      end
      WARMUP: begin
        if (cnt_r == WARM_LAST) state_s = IDLE;
        else                    state_s = WARMUP;
      end
      default: state_s = RST_PH;
    endcase

    // A request outside IDLE is dropped but remembered until reset.
    if (load_rise_s && (state_r != IDLE)) ovr_s = 1'b1;
    else                                   ovr_s = ovr_r;

    if ((state_s != state_r) || (state_r == IDLE) || (state_r == LOAD)) cnt_s = {CNT_W{1'b0}};
    else                                                                cnt_s = cnt_r + CNT_W'(1'b1);
  end

  // State register and registered outputs decoded from the next state.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r     <= RST_PH;
      cnt_r       <= {CNT_W{1'b0}};
      seed_r      <= SEED_DEFAULT;
      ovr_r       <= 1'b0;
      prng_rst_r  <= 1'b1;
      seed_load_r <= 1'b0;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      seed_r      <= seed_s;
      ovr_r       <= ovr_s;
      prng_rst_r  <= (state_s == RST_PH);
      seed_load_r <= (state_s == LOAD);
      ready_r     <= (state_s == IDLE);
    end
  end

  assign bus.seed_o      = seed_r;
  assign bus.seed_load_o = seed_load_r;
  assign bus.prng_rst_o  = prng_rst_r;
  assign bus.ready_o     = ready_r;
  assign bus.overrun_o   = ovr_r;

endmodule

// File: tb/tb_acorn_seed_ctrl.sv
// Directed bench for acorn_seed_ctrl: auto-seed, source selection, zero guard,
// overrun, mid-sequence reset, held load level and sub-cycle glitch.
module tb_acorn_seed_ctrl;
  import acorn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   pulses;

  acorn_seed_ctrl_if bus_if ();

  acorn_seed_ctrl #(.RST_CYCLES(4), .WARMUP_CYCLES(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Starts at the negedge after the RST_PH entry edge; checks the 22-cycle profile.
  task automatic run_seq(input string tag, input logic [11:0] exp_seed, input logic ovr0, input bit inject);
    for (int k = 0; k < 22; k++) begin
      if (k > 0) cyc(1);
      chk1($sformatf("%s.rst%0d", tag, k), bus_if.prng_rst_o, (k < 4) ? 1'b1 : 1'b0);
      chk1($sformatf("%s.ld%0d", tag, k), bus_if.seed_load_o, (k == 4) ? 1'b1 : 1'b0);
      chk1($sformatf("%s.rdy%0d", tag, k), bus_if.ready_o, (k >= 21) ? 1'b1 : 1'b0);
      chk1($sformatf("%s.ovr%0d", tag, k), bus_if.overrun_o, (ovr0 || (inject && k >= 13)) ? 1'b1 : 1'b0);
      chk12($sformatf("%s.seed%0d", tag, k), bus_if.seed_o, exp_seed);
      if (inject && k == 2)  bus_if.load_i = 1'b0;
      if (inject && k == 10) bus_if.load_i = 1'b1;
    end
  endtask

  // Raises load_i in IDLE and returns at the negedge after the RST_PH entry edge.
  task automatic trigger(input string tag);
    bus_if.load_i = 1'b1;
    cyc(2);
    chk1({tag, ".lat_rst"}, bus_if.prng_rst_o, 1'b0);
    chk1({tag, ".lat_rdy"}, bus_if.ready_o, 1'b1);
    cyc(1);
  endtask

  task automatic settle();
    bus_if.load_i = 1'b0;
    cyc(4);
  endtask

  initial begin
    bus_if.load_i      = 1'b0;
    bus_if.select_i    = 2'b00;
    bus_if.gpio_seed_i = 12'h000;
    bus_if.la_seed_i   = 12'h000;
    bus_if.prng_out_i  = 12'h000;

    // Reset values, then auto-seed with the default seed.
    cyc(3);
    chk12("rst.seed", bus_if.seed_o, 12'hACE);
    chk1("rst.prng_rst", bus_if.prng_rst_o, 1'b1);
    chk1("rst.ld", bus_if.seed_load_o, 1'b0);
    chk1("rst.rdy", bus_if.ready_o, 1'b0);
    chk1("rst.ovr", bus_if.overrun_o, 1'b0);
    rst = 1'b0;
    run_seq("t1", 12'hACE, 1'b0, 1'b0);

    // GPIO seed; bus change after the load edge must not leak through.
    settle();
    bus_if.select_i    = 2'b00;
    bus_if.gpio_seed_i = 12'h5A3;
    bus_if.la_seed_i   = 12'h0F0;
    bus_if.prng_out_i  = 12'h00F;
    trigger("t2");
    bus_if.gpio_seed_i = 12'h111;
    run_seq("t2", 12'h5A3, 1'b0, 1'b0);

    // LA seed of zero hits the zero guard.
    settle();
    bus_if.select_i    = 2'b01;
    bus_if.la_seed_i   = 12'h000;
    bus_if.gpio_seed_i = 12'h5A3;
    trigger("t3a");
    run_seq("t3a", 12'hACE, 1'b0, 1'b0);

    // PRNG feedback seed.
    settle();
    bus_if.select_i   = 2'b10;
    bus_if.prng_out_i = 12'h3C7;
    trigger("t3b");
    bus_if.prng_out_i = 12'h000;
    run_seq("t3b", 12'h3C7, 1'b0, 1'b0);

    // Second edge during warm-up: overrun, timing unchanged.
    settle();
    bus_if.select_i    = 2'b00;
    bus_if.gpio_seed_i = 12'h246;
    trigger("t4");
    run_seq("t4", 12'h246, 1'b0, 1'b1);
    cyc(5);
    chk1("t4.sticky", bus_if.overrun_o, 1'b1);

    // Reset in RST_PH of a reload aborts it and restarts the auto-seed.
    settle();
    bus_if.gpio_seed_i = 12'h777;
    trigger("t5");
    chk12("t5.seed", bus_if.seed_o, 12'h777);
    chk1("t5.ovr", bus_if.overrun_o, 1'b1);
    cyc(2);
    chk1("t5.rst_ph", bus_if.prng_rst_o, 1'b1);
    rst = 1'b1;
    bus_if.load_i = 1'b0;
    cyc(1);
    rst = 1'b0;
    chk1("t5.ld_in_rst", bus_if.seed_load_o, 1'b0);
    run_seq("t5auto", 12'hACE, 1'b0, 1'b0);

    // Level held for 100 cycles gives exactly one reseed (constant source).
    cyc(3);
    bus_if.select_i    = 2'b11;
    bus_if.gpio_seed_i = 12'h999;
    trigger("t6");
    run_seq("t6", 12'hACE, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 78; i++) begin
      cyc(1);
      if (bus_if.prng_rst_o || bus_if.seed_load_o) pulses++;
    end
    chk12("t6.extra", 12'(pulses), 12'd0);
    chk1("t6.rdy", bus_if.ready_o, 1'b1);
    chk1("t6.ovr", bus_if.overrun_o, 1'b0);
    settle();

    // Sub-cycle glitch between clock edges is never sampled.
    for (int g = 0; g < 2; g++) begin
      #1 bus_if.load_i = 1'b1;
      #2 bus_if.load_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
        cyc(1);
        chk1($sformatf("glitch%0d.rst%0d", g, i), bus_if.prng_rst_o, 1'b0);
        chk1($sformatf("glitch%0d.rdy%0d", g, i), bus_if.ready_o, 1'b1);
      end
    end
    chk1("glitch.ovr", bus_if.overrun_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
